// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - state enum, opcode/funct constants and mux/ALU encodings shared with the datapath
package mc_ctrl_pkg;

  localparam int WORD_W = 16;
  localparam int ST_W   = 4;

  typedef enum logic [ST_W-1:0] {
    S_IF      = 4'd0,
    S_ID      = 4'd1,
    S_EX_R    = 4'd2,
    S_EX_I    = 4'd3,
    S_WB      = 4'd4,
    S_EX_BR   = 4'd5,
    S_EX_J    = 4'd6,
    S_EX_JR   = 4'd7,
    S_EX_ADDR = 4'd8,
    S_MEM_RD  = 4'd9,
    S_MEM_WR  = 4'd10,
    S_EX_WWD  = 4'd11,
    S_HALT    = 4'd12
  } state_t;

  localparam logic [3:0] OP_BNE   = 4'd0;
  localparam logic [3:0] OP_BEQ   = 4'd1;
  localparam logic [3:0] OP_BGZ   = 4'd2;
  localparam logic [3:0] OP_BLZ   = 4'd3;
  localparam logic [3:0] OP_ADI   = 4'd4;
  localparam logic [3:0] OP_ORI   = 4'd5;
  localparam logic [3:0] OP_LHI   = 4'd6;
  localparam logic [3:0] OP_LWD   = 4'd7;
  localparam logic [3:0] OP_SWD   = 4'd8;
  localparam logic [3:0] OP_JMP   = 4'd9;
  localparam logic [3:0] OP_JAL   = 4'd10;
  localparam logic [3:0] OP_RTYPE = 4'd15;

  localparam logic [5:0] FN_JPR = 6'd25;
  localparam logic [5:0] FN_JRL = 6'd26;
  localparam logic [5:0] FN_WWD = 6'd28;
  localparam logic [5:0] FN_HLT = 6'd29;

  localparam logic [1:0] ALU_ADD     = 2'd0;
  localparam logic [1:0] ALU_BRANCH  = 2'd1;
  localparam logic [1:0] ALU_FUNCT   = 2'd2;
  localparam logic [1:0] ALU_JTARGET = 2'd3;

  localparam logic [1:0] A_PC   = 2'd0;
  localparam logic [1:0] A_REG1 = 2'd1;

  localparam logic [1:0] B_REG2 = 2'd0;
  localparam logic [1:0] B_ONE  = 2'd1;
  localparam logic [1:0] B_IMM  = 2'd2;
  localparam logic [1:0] B_ZERO = 2'd3;

  localparam logic [1:0] MTR_ALU = 2'd0;
  localparam logic [1:0] MTR_MEM = 2'd1;
  localparam logic [1:0] MTR_PC  = 2'd2;

  // R-type funct codes 0..7 are plain ALU operations
  function automatic logic is_alu_funct(input logic [5:0] funct);
    return funct < 6'd8;
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// rtl/mc_control_fsm_if.sv - controller <-> datapath/memory bundle; MC_CTRL_PERF_EN adds perf counters
interface mc_control_fsm_if;
  import mc_ctrl_pkg::*;

  logic [WORD_W-1:0] instruction_reg;
  logic              bcond;
  logic              mem_ack;
  logic              i_or_d;
  logic              mem_read;
  logic              mem_write;
  logic              ir_write;
  logic [1:0]        mem_to_reg;
  logic              reg_write;
  logic              pc_to_reg;
  logic [1:0]        alu_src_A;
  logic [1:0]        alu_src_B;
  logic [1:0]        alu_op;
  logic              pc_src;
  logic              pc_write;
  logic              new_inst;
  logic              wwd;
  logic              halt;
`ifdef MC_CTRL_PERF_EN
  logic [15:0]       num_inst;
  logic [15:0]       num_cycle;
`endif

  modport master (
    input  instruction_reg, bcond, mem_ack,
    output i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_write, pc_to_reg,
    output alu_src_A, alu_src_B, alu_op, pc_src, pc_write, new_inst, wwd, halt
`ifdef MC_CTRL_PERF_EN
    , output num_inst, num_cycle
`endif
  );

  modport slave (
    output instruction_reg, bcond, mem_ack,
    input  i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_write, pc_to_reg,
    input  alu_src_A, alu_src_B, alu_op, pc_src, pc_write, new_inst, wwd, halt
`ifdef MC_CTRL_PERF_EN
    , input num_inst, num_cycle
`endif
  );

endinterface

// File: rtl/mc_ctrl_decode.sv
// rtl/mc_ctrl_decode.sv - IR decode: state to enter after ID plus link/store qualifiers for EX states
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [WORD_W-1:0] instruction_reg,
  output state_t            id_next,
  output logic              link,
  output logic              store
);

  logic [3:0] opcode;
  logic [5:0] funct;
  logic       unused_ir_bits;

  assign opcode         = instruction_reg[15:12];
  assign funct          = instruction_reg[5:0];
  assign unused_ir_bits = ^instruction_reg[11:6];

  always_comb begin
    id_next = S_IF;
    link    = 1'b0;
    store   = 1'b0;
    case (opcode)
      OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: id_next = S_EX_BR;
      OP_ADI, OP_ORI, OP_LHI:         id_next = S_EX_I;
      OP_LWD:                         id_next = S_EX_ADDR;
      OP_SWD: begin
        id_next = S_EX_ADDR;
        store   = 1'b1;
      end
      OP_JMP:                         id_next = S_EX_J;
      OP_JAL: begin
        id_next = S_EX_J;
        link    = 1'b1;
      end
      OP_RTYPE: begin
        if (is_alu_funct(funct)) begin
          id_next = S_EX_R;
        end else begin
          case (funct)
            FN_JPR:  id_next = S_EX_JR;
            FN_JRL: begin
              id_next = S_EX_JR;
              link    = 1'b1;
            end
            FN_WWD:  id_next = S_EX_WWD;
            FN_HLT:  id_next = S_HALT;
            default: id_next = S_IF;
          endcase
        end
      end
      default: id_next = S_IF;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multi-cycle TSC control FSM; MC_CTRL_PERF_EN adds num_inst/num_cycle counters
module mc_control_fsm
  import mc_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  mc_control_fsm_if.master  bus
);

  state_t state;
  state_t next_state;
  state_t id_next;
  logic   link;
  logic   store;

  mc_ctrl_decode u_decode (
    .instruction_reg (bus.instruction_reg),
    .id_next         (id_next),
    .link            (link),
    .store           (store)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IF;
    else       state <= next_state;
  end

  // Everything is held at zero during the reset cycle so no strobe leaks out of an aborted op
  always_comb begin
    next_state     = state;
    bus.i_or_d     = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.mem_to_reg = MTR_ALU;
    bus.reg_write  = 1'b0;
    bus.pc_to_reg  = 1'b0;
    bus.alu_src_A  = A_PC;
    bus.alu_src_B  = B_REG2;
    bus.alu_op     = ALU_ADD;
    bus.pc_src     = 1'b0;
    bus.pc_write   = 1'b0;
    bus.new_inst   = 1'b0;
    bus.wwd        = 1'b0;
    bus.halt       = 1'b0;
    if (!reset) begin
      case (state)
        S_IF: begin
          bus.mem_read  = 1'b1;
          bus.alu_src_B = B_ONE;
          if (bus.mem_ack) begin
            bus.ir_write = 1'b1;
            bus.pc_write = 1'b1;
            bus.new_inst = 1'b1;
            next_state   = S_ID;
          end
        end
        S_ID: begin
          bus.alu_src_B = B_IMM;
          next_state    = id_next;
        end
        S_EX_R: begin
          bus.alu_src_A = A_REG1;
          bus.alu_op    = ALU_FUNCT;
          next_state    = S_WB;
        end
        S_EX_I: begin
          bus.alu_src_A = A_REG1;
          bus.alu_src_B = B_IMM;
          bus.alu_op    = ALU_FUNCT;
          next_state    = S_WB;
        end
        S_WB: begin
          bus.reg_write = 1'b1;
          next_state    = S_IF;
        end
        S_EX_BR: begin
          bus.alu_src_A = A_REG1;
          bus.alu_op    = ALU_BRANCH;
          if (bcond_taken()) begin
            bus.pc_src   = 1'b1;
            bus.pc_write = 1'b1;
          end
          next_state = S_IF;
        end
        S_EX_J: begin
          bus.alu_src_B = B_IMM;
          bus.alu_op    = ALU_JTARGET;
          bus.pc_write  = 1'b1;
          if (link) begin
            bus.reg_write  = 1'b1;
            bus.mem_to_reg = MTR_PC;
            bus.pc_to_reg  = 1'b1;
          end
          next_state = S_IF;
        end
        S_EX_JR: begin
          bus.alu_src_A = A_REG1;
          bus.alu_src_B = B_ZERO;
          bus.pc_write  = 1'b1;
          if (link) begin
            bus.reg_write  = 1'b1;
            bus.mem_to_reg = MTR_PC;
            bus.pc_to_reg  = 1'b1;
          end
          next_state = S_IF;
        end
        S_EX_ADDR: begin
          bus.alu_src_A = A_REG1;
          bus.alu_src_B = B_IMM;
          next_state    = store ? S_MEM_WR : S_MEM_RD;
        end
        S_MEM_RD: begin
          bus.i_or_d   = 1'b1;
          bus.mem_read = 1'b1;
          if (bus.mem_ack) begin
            bus.reg_write  = 1'b1;
            bus.mem_to_reg = MTR_MEM;
            next_state     = S_IF;
          end
        end
        S_MEM_WR: begin
          bus.i_or_d    = 1'b1;
          bus.mem_write = 1'b1;
          if (bus.mem_ack) next_state = S_IF;
        end
        S_EX_WWD: begin
          bus.alu_src_A = A_REG1;
          bus.alu_src_B = B_ZERO;
          bus.wwd       = 1'b1;
          next_state    = S_IF;
        end
        S_HALT: begin
          bus.halt = 1'b1;
        end
        default: next_state = S_IF;
      endcase
    end
  end

  function automatic logic bcond_taken();
    return bus.bcond;
  endfunction

`ifdef MC_CTRL_PERF_EN
  logic [15:0] num_inst;
  logic [15:0] num_cycle;
  logic        halt_seen;

  // The cycle that first sits in HALT is still counted; the counters freeze from the next one
  always_ff @(posedge clk) begin
    if (reset) begin
      num_inst  <= 16'd0;
      num_cycle <= 16'd0;
      halt_seen <= 1'b0;
    end else begin
      if (!halt_seen)   num_cycle <= num_cycle + 16'd1;
      if (bus.new_inst) num_inst  <= num_inst + 16'd1;
      if (state == S_HALT) halt_seen <= 1'b1;
    end
  end

  assign bus.num_inst  = num_inst;
  assign bus.num_cycle = num_cycle;
`endif

endmodule
